// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared states, control words, modes and saturating mix for psram_loop_ctrl
package psram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    // Control word order: {Adv, Clk, CS, OE, WR, LB, UB}, all active-low
    localparam logic [6:0] CTRL_IDLE  = 7'b1111111;
    localparam logic [6:0] CTRL_READ  = 7'b0000100;
    localparam logic [6:0] CTRL_WRITE = 7'b0001000;

    localparam logic [1:0] MODE_PLAY     = 2'd0;
    localparam logic [1:0] MODE_RECORD   = 2'd1;
    localparam logic [1:0] MODE_OVERDUB  = 2'd2;
    localparam logic [1:0] MODE_PLAY_ALT = 2'd3;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {a[15], a} + {b[15], b};
        if (sum[16] != sum[15]) begin
            sat_add = sum[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            sat_add = sum[15:0];
        end
    endfunction

endpackage

// File: rtl/psram_loop_ctrl_sample_tick.sv
// rtl/psram_loop_ctrl_sample_tick.sv - sample-rate divider producing a registered one-cycle tick
module sample_tick #(
    parameter int PULSE_DIV = 3200
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        tick_d = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/psram_loop_ctrl.sv
// rtl/psram_loop_ctrl.sv - audio loop-buffer controller for asynchronous PSRAM (overdub built with PSRAM_OVERDUB_EN)
module psram_loop_ctrl
    import psram_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int LOOP_LEN    = 384000,
    parameter int PULSE_DIV   = 3200,
    parameter int WAIT_CYCLES = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [15:0]       rec_sample,
    input  logic              clr_status,
    output logic [15:0]       play_sample,
    output logic              play_valid,
    output logic              loop_wrap,
    output logic              overrun,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [15:0]       MemDB,
    output logic [22:0]       MemAdr,
    output logic              RamAdv,
    output logic              RamClk,
    output logic              RamCS,
    output logic              MemOE,
    output logic              MemWR,
    output logic              RamLB,
    output logic              RamUB
);

    localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LOOP_LEN - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       play_q, play_d;
    logic              valid_q, valid_d;
    logic              wrap_q, wrap_d;
    logic              ovr_q, ovr_d;
    logic              tick;
    logic              advance;
    logic              drive;
    logic [6:0]        ctrl;
`ifdef PSRAM_OVERDUB_EN
    logic              ovd_q, ovd_d;
`endif

    sample_tick #(.PULSE_DIV(PULSE_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        play_d  = play_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        ovr_d   = ovr_q;
        advance = 1'b0;
        drive   = 1'b0;
        ctrl    = CTRL_IDLE;
`ifdef PSRAM_OVERDUB_EN
        ovd_d   = ovd_q;
`endif
        // Set is evaluated after clear so a colliding tick keeps the flag
        if (clr_status) ovr_d = 1'b0;
        if (tick && state_q != IDLE) ovr_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (tick && enable) begin
                    wdata_d = rec_sample;
                    wait_d  = '0;
`ifdef PSRAM_OVERDUB_EN
                    ovd_d   = 1'b0;
`endif
                    case (mode)
                        MODE_RECORD:  state_d = WRITE;
                        MODE_OVERDUB: begin
                            state_d = READ;
`ifdef PSRAM_OVERDUB_EN
                            ovd_d   = 1'b1;
`endif
                        end
                        MODE_PLAY, MODE_PLAY_ALT: state_d = READ;
                    endcase
                end
            end
            READ: begin
                ctrl = CTRL_READ;
                if (wait_q == WAIT_LAST) begin
                    play_d  = MemDB;
                    valid_d = 1'b1;
                    wait_d  = '0;
`ifdef PSRAM_OVERDUB_EN
                    if (ovd_q) begin
                        state_d = WRITE;
                        wdata_d = sat_add(MemDB, wdata_q);
                    end else begin
                        state_d = IDLE;
                        advance = 1'b1;
                    end
`else
                    state_d = IDLE;
                    advance = 1'b1;
`endif
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WRITE: begin
                ctrl  = CTRL_WRITE;
                drive = 1'b1;
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = IDLE;
                    advance = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (addr_q == ADDR_LAST) begin
                addr_d = '0;
                wrap_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            play_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            play_q  <= play_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef PSRAM_OVERDUB_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovd_q <= 1'b0;
        else      ovd_q <= ovd_d;
    end
`endif

    // Pins decode straight from the state register so reset idles them asynchronously
    assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = ctrl;
    assign MemDB       = drive ? wdata_q : 16'bz;
    assign MemAdr      = 23'(addr_q);
    assign addr        = addr_q;
    assign play_sample = play_q;
    assign play_valid  = valid_q;
    assign loop_wrap   = wrap_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_psram_loop_ctrl.sv
// tb/tb_psram_loop_ctrl.sv - randomized bench for psram_loop_ctrl against a window-level reference model
module tb_psram_loop_ctrl;

    localparam int W  = 6;
    localparam int PD = 32;
    localparam int LL = 4;
    localparam int AW = 4;
    localparam int NT = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, enable, clr_status;
    logic [1:0]        mode;
    logic [15:0]       rec_sample;
    logic [15:0]       play_sample;
    logic              play_valid, loop_wrap, overrun;
    logic [AW-1:0]     addr;
    wire  [15:0]       mem_db;
    logic [22:0]       mem_adr;
    logic              ram_adv, ram_clk, ram_cs, mem_oe, mem_wr, ram_lb, ram_ub;
    logic [6:0]        ctrl;

    pullup pu_db (mem_db);

    psram_loop_ctrl #(.ADDR_W(AW), .LOOP_LEN(LL), .PULSE_DIV(PD), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .rec_sample(rec_sample),
        .clr_status(clr_status), .play_sample(play_sample), .play_valid(play_valid),
        .loop_wrap(loop_wrap), .overrun(overrun), .addr(addr), .MemDB(mem_db), .MemAdr(mem_adr),
        .RamAdv(ram_adv), .RamClk(ram_clk), .RamCS(ram_cs), .MemOE(mem_oe), .MemWR(mem_wr),
        .RamLB(ram_lb), .RamUB(ram_ub)
    );
    assign ctrl = {ram_adv, ram_clk, ram_cs, mem_oe, mem_wr, ram_lb, ram_ub};

    // PSRAM model: preloaded while in reset, combinational read, write on the clock
    logic [15:0] mem [4];
    assign mem_db = (!ram_cs && !mem_oe) ? mem[mem_adr[1:0]] : 16'bz;
    always @(posedge clk) begin
        if (!rst) begin
            mem[0] <= 16'h1234;
            mem[1] <= 16'h0000;
            mem[2] <= 16'h7000;
            mem[3] <= 16'h9000;
        end else if (!ram_cs && !mem_wr) begin
            mem[mem_adr[1:0]] <= mem_db;
        end
    end

    // Short-period instance where ticks overlap accesses
    logic              rst2, en2, clr2;
    logic [1:0]        md2;
    logic [15:0]       rec2, ps2;
    logic              pv2, wrap2, ovr2;
    logic [AW-1:0]     addr2;
    wire  [15:0]       mem_db2;
    logic [22:0]       adr2;
    logic              adv2, rclk2, cs2, oe2, wr2, lb2, ub2;
    logic              ovr_done = 1'b0;

    psram_loop_ctrl #(.ADDR_W(AW), .LOOP_LEN(LL), .PULSE_DIV(5), .WAIT_CYCLES(W)) dut_ovr (
        .clk(clk), .rst(rst2), .enable(en2), .mode(md2), .rec_sample(rec2),
        .clr_status(clr2), .play_sample(ps2), .play_valid(pv2),
        .loop_wrap(wrap2), .overrun(ovr2), .addr(addr2), .MemDB(mem_db2), .MemAdr(adr2),
        .RamAdv(adv2), .RamClk(rclk2), .RamCS(cs2), .MemOE(oe2), .MemWR(wr2),
        .RamLB(lb2), .RamUB(ub2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

`ifdef PSRAM_OVERDUB_EN
    function automatic logic [15:0] mix(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction
`endif

    // Reference model: access windows in absolute cycle numbers since reset release
    int          rd_s = -100, rd_e = -100, wr_s = -100, wr_e = -100, acc_end = -100, wrap_at = -100;
    int          exp_addr = 0, wr_addr = 0, rst_at = -1;
    logic [15:0] exp_ps = 16'h0000, rv = 16'h0000, wd = 16'h0000;
    bit          rst_done = 1'b0;

    initial begin
        logic [6:0] exp_ctrl;
        bit         in_rd, in_wr;
        int         n;
        rst = 1'b0; enable = 1'b0; mode = 2'd0; rec_sample = 16'h0; clr_status = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ctrl", ctrl, 7'b1111111);
        check_eq("rst_db", mem_db, 16'hFFFF);
        check_eq("rst_play", {play_sample, play_valid, loop_wrap, overrun}, 19'h0);
        check_eq("rst_addr", addr, 0);
        rst = 1'b1;

        for (int k = 1; k <= (NT + 8) * PD && !rst_done; k++) begin
            @(negedge clk);
            if (k == rd_e + 1)    exp_ps = rv;
            if (k == acc_end + 1) exp_addr = (exp_addr + 1) % LL;
            in_rd    = (k >= rd_s && k <= rd_e);
            in_wr    = (k >= wr_s && k <= wr_e);
            exp_ctrl = in_rd ? 7'b0000100 : (in_wr ? 7'b0001000 : 7'b1111111);
            check_eq("ctrl", ctrl, exp_ctrl);
            check_eq("mem_adr", mem_adr, exp_addr);
            check_eq("addr", addr, exp_addr);
            check_eq("play_sample", play_sample, exp_ps);
            check_eq("play_valid", play_valid, k == rd_e + 1);
            check_eq("loop_wrap", loop_wrap, k == wrap_at);
            check_eq("overrun", overrun, 0);
            if (in_wr)       check_eq("db_write", mem_db, wd);
            else if (!in_rd) check_eq("db_idle", mem_db, 16'hFFFF);
            if (k == wr_e + 1) check_eq("mem_written", mem[wr_addr], wd);

            if (k == 40)  check_eq("play_1234", play_sample, 16'h1234);
            if (k == 72)  check_eq("rec_beef", mem[1], 16'hBEEF);
`ifdef PSRAM_OVERDUB_EN
            if (k == 125) check_eq("ovd_sat_pos", mem[2], 16'h7FFF);
            if (k == 155) check_eq("ovd_sat_neg", mem[3], 16'h8000);
`else
            if (k == 125) check_eq("ovd_off_pos", mem[2], 16'h7000);
            if (k == 155) check_eq("ovd_off_neg", mem[3], 16'h9000);
`endif
            if (k == 155) check_eq("wrap_addr", addr, 0);

            if (k == rst_at) begin
                #2 rst = 1'b0;
                #1;
                check_eq("rstw_ctrl", ctrl, 7'b1111111);
                check_eq("rstw_db", mem_db, 16'hFFFF);
                check_eq("rstw_addr", addr, exp_addr);
                rst_done = 1'b1;
            end else if (k % PD == 0) begin
                n = k / PD;
                case (n)
                    1: begin enable = 1'b1; mode = 2'd0; rec_sample = 16'h0000; end
                    2: begin enable = 1'b1; mode = 2'd1; rec_sample = 16'hBEEF; end
                    3: begin enable = 1'b1; mode = 2'd2; rec_sample = 16'h2000; end
                    4: begin enable = 1'b1; mode = 2'd2; rec_sample = 16'hE000; end
                    default: begin
                        enable     = ($urandom_range(3) != 0);
                        mode       = 2'($urandom_range(3));
                        rec_sample = 16'($urandom);
                        if (n >= NT) begin
                            enable = 1'b1;
                            if (exp_addr != 0 || k <= acc_end) mode = 2'd0;
                            else begin mode = 2'd1; rst_at = k + 3; end
                        end
                    end
                endcase
                if (enable && k > acc_end) begin
                    rd_s = -100; rd_e = -100; wr_s = -100; wr_e = -100;
                    rv = mem[exp_addr];
                    wr_addr = exp_addr;
                    if (mode == 2'd1) begin
                        wd = rec_sample; wr_s = k + 1; wr_e = k + 1 + W; acc_end = wr_e;
                    end else begin
                        rd_s = k + 1; rd_e = k + 1 + W; acc_end = rd_e;
`ifdef PSRAM_OVERDUB_EN
                        if (mode == 2'd2) begin
                            wd = mix(rv, rec_sample); wr_s = rd_e + 1; wr_e = rd_e + 1 + W; acc_end = wr_e;
                        end
`endif
                    end
                    wrap_at = (exp_addr == LL - 1) ? acc_end + 1 : -100;
                end
            end else begin
                enable     = 1'($urandom);
                mode       = 2'($urandom);
                rec_sample = 16'($urandom);
            end
        end
        check_eq("rst_test_reached", rst_done, 1);

        for (int i = 0; i < 200 && !ovr_done; i++) @(negedge clk);
        check_eq("ovr_test_done", ovr_done, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Ticks every 5 cycles against 7-cycle writes: ticks at 10, 20 collide, 15 starts a new access
    initial begin
        int wr_cnt;
        rst2 = 1'b0; en2 = 1'b0; md2 = 2'd1; rec2 = 16'h1111; clr2 = 1'b0;
        wr_cnt = 0;
        repeat (3) @(negedge clk);
        rst2 = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k <= 14 && !wr2) wr_cnt++;
            if (k == 11) check_eq("ovr_set", ovr2, 1);
            if (k == 13) begin
                check_eq("ovr_wr_len", wr_cnt, 7);
                check_eq("ovr_addr1", addr2, 1);
            end
            if (k == 18) check_eq("ovr_clear", ovr2, 0);
            if (k == 21) check_eq("ovr_set_wins", ovr2, 1);
            if (k == 23) check_eq("ovr_addr2", addr2, 2);
            if (k == 30) check_eq("ovr_sticky", ovr2, 1);
            if (k == 32) check_eq("ovr_clr_idle", ovr2, 0);
            if (k == 33) check_eq("ovr_addr_hold", addr2, 2);
            en2  = (k < 22);
            clr2 = (k == 17 || k == 20 || k == 31);
        end
        ovr_done = 1'b1;
    end

endmodule
